ro_puf_ctrl: RTL and testbench

Sequencer for the bank of eight ring oscillators. Per response bit, it decodes a pair of oscillator indices from the challenge, enables only those two, counts their rising edges over a fixed clock window and compares the counts. The comparison results are assembled into a multi-bit PUF response. The block sits between the challenge/response host interface and the raw oscillator bank. It is the only driver of the oscillator enables.

---
 rtl/ro_puf_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_ro_puf_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl -- ring-oscillator PUF sequencer.
//
// For each response bit the controller takes one oscillator pair (A_i, B_i)
// from the latched challenge. It enables only those two oscillators, lets them
// settle, and then counts their rising edges over a fixed window of clk
// cycles. The two counts are compared to give response[i] and tie[i].
// This block is the sole driver of the oscillator enables.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   start      request a new challenge (ignored while busy)
//   challenge  pair list: [6i+2:6i] = A_i, [6i+5:6i+3] = B_i
//   ro_out     raw oscillator outputs, asynchronous to clk
//   ro_en      registered per-oscillator enables (at most two high)
//   busy       high from start acceptance through the done cycle
//   done       one-cycle pulse; response/tie valid from this cycle on
//   response   bit i = (count A_i > count B_i)
//   tie        bit i = counts equal, or A_i == B_i
//
// Limitation: each oscillator is sampled by clk through a two-flop
// synchroniser followed by an edge-history flop. Edge counts are exact only
// while the oscillator period is longer than two clk periods. Faster
// oscillators alias to a lower count.

module ro_puf_ctrl #(
  parameter int RESP_BITS = 4,
  parameter int WINDOW    = 1024,
  parameter int SETTLE    = 4,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [6*RESP_BITS-1:0] challenge,
  input  logic [7:0]             ro_out,
  output logic [7:0]             ro_en,
  output logic                   busy,
  output logic                   done,
  output logic [RESP_BITS-1:0]   response,
  output logic [RESP_BITS-1:0]   tie
);

  localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int TMR_W = $clog2(WINDOW + SETTLE) + 1;

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(RESP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_COMPARE,
    S_DONE
  } state_t;

  // Counter increment that holds at full scale instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Enable mask for one pair. A degenerate pair (A == B) never runs.
  function automatic logic [7:0] pair_enable(input logic [2:0] a,
                                             input logic [2:0] b,
                                             input logic       active);
    logic [7:0] en;
    en = '0;
    if (active && (a != b)) begin
      en[a] = 1'b1;
      en[b] = 1'b1;
    end
    return en;
  endfunction

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [TMR_W-1:0]         tmr_q, tmr_d;
  logic [6*RESP_BITS-1:0]   chal_q, chal_d;
  logic [CNT_W-1:0]         cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]         cnt_b_q, cnt_b_d;
  logic [RESP_BITS-1:0]     resp_q, resp_d;
  logic [RESP_BITS-1:0]     tie_q, tie_d;
  logic [7:0]               ro_en_q, ro_en_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [7:0]               sync1_q, sync1_d;
  logic [7:0]               sync2_q, sync2_d;
  logic [7:0]               hist_q, hist_d;

  logic [2:0]               pair_a, pair_b;
  logic                     pair_eq;
  logic [2:0]               next_a, next_b;
  logic                     next_active;
  logic [7:0]               ro_rise;

  // Oscillator synchroniser and edge detector. This runs continuously, and
  // edges are only consumed while in MEASURE.
  always_comb begin
    sync1_d = ro_out;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    ro_rise = sync2_q & ~hist_q;
  end

  // Pair currently being processed.
  always_comb begin
    pair_a  = chal_q[int'(idx_q)*6 +: 3];
    pair_b  = chal_q[int'(idx_q)*6 + 3 +: 3];
    pair_eq = (pair_a == pair_b);
  end

  // Sequencer next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    chal_d  = chal_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    resp_d  = resp_q;
    tie_d   = tie_q;

    unique case (state_q)
      S_IDLE: begin
        // busy_q is still high during the done cycle, so a start that
        // coincides with done is ignored.
        if (start && !busy_q) begin
          chal_d  = challenge;
          resp_d  = '0;
          tie_d   = '0;
          idx_d   = '0;
          tmr_d   = '0;
          cnt_a_d = '0;
          cnt_b_d = '0;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        cnt_a_d = '0;
        cnt_b_d = '0;
        if (pair_eq) begin
          // Nothing to measure; spend a single cycle here and go compare.
          tmr_d   = '0;
          state_d = S_COMPARE;
        end else if (tmr_q == SETTLE_LAST) begin
          tmr_d   = '0;
          state_d = S_MEASURE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_MEASURE: begin
        if (ro_rise[pair_a]) cnt_a_d = sat_inc(cnt_a_q);
        if (ro_rise[pair_b]) cnt_b_d = sat_inc(cnt_b_q);
        if (tmr_q == WINDOW_LAST) begin
          tmr_d   = '0;
          state_d = S_COMPARE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_COMPARE: begin
        resp_d[idx_q] = !pair_eq && (cnt_a_q > cnt_b_q);
        tie_d[idx_q]  = pair_eq || (cnt_a_q == cnt_b_q);
        cnt_a_d       = '0;
        cnt_b_d       = '0;
        tmr_d         = '0;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_SETTLE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs. The enables are computed from the next state and the
  // next pair, so they switch on the same edge as the state they belong to.
  // done is registered one cycle behind the DONE state, and busy is stretched
  // by one cycle so that it still covers that cycle.
  always_comb begin
    next_a      = chal_d[int'(idx_d)*6 +: 3];
    next_b      = chal_d[int'(idx_d)*6 + 3 +: 3];
    next_active = (state_d == S_SETTLE) || (state_d == S_MEASURE);
    ro_en_d     = pair_enable(next_a, next_b, next_active);
    busy_d      = (state_d != S_IDLE) || (state_q == S_DONE);
    done_d      = (state_q == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmr_q   <= '0;
      chal_q  <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      resp_q  <= '0;
      tie_q   <= '0;
      ro_en_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      chal_q  <= chal_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
      ro_en_q <= ro_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign ro_en    = ro_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign response = resp_q;
  assign tie      = tie_q;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Testbench for ro_puf_ctrl. It uses three instances: a 1-bit response, a
// 4-bit response, and a 1-bit response with 4-bit saturating counters.
// All three share the clock, the reset and a modelled oscillator bank.

module tb_ro_puf_ctrl;

  localparam int W = 64;
  localparam int S = 4;

  typedef struct packed {
    logic [3:0] resp;
    logic [3:0] tie;
    int         lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ro_out;

  logic        st1, st4, sts;
  logic [5:0]  ch1, chs;
  logic [23:0] ch4;
  logic [7:0]  en1, en4, ens;
  logic        busy1, busy4, busys;
  logic        done1, done4, dones;
  logic [0:0]  resp1, tie1, resps, ties;
  logic [3:0]  resp4, tie4;

  int per [8] = '{8, 8, 8, 8, 8, 8, 8, 8};
  int tick_n;
  int cyc_now = 0;
  int t0;
  int done1_cnt = 0;
  int n_checks = 0;
  int n_pass = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc_now++;
  always @(negedge clk) if (done1 === 1'b1) done1_cnt++;

  ro_puf_ctrl #(.RESP_BITS(1), .WINDOW(W), .SETTLE(S), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .challenge(ch1), .ro_out(ro_out),
    .ro_en(en1), .busy(busy1), .done(done1), .response(resp1), .tie(tie1));

  ro_puf_ctrl #(.RESP_BITS(4), .WINDOW(W), .SETTLE(S), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .challenge(ch4), .ro_out(ro_out),
    .ro_en(en4), .busy(busy4), .done(done4), .response(resp4), .tie(tie4));

  ro_puf_ctrl #(.RESP_BITS(1), .WINDOW(W), .SETTLE(S), .CNT_W(4)) duts (
    .clk(clk), .rst(rst), .start(sts), .challenge(chs), .ro_out(ro_out),
    .ro_en(ens), .busy(busys), .done(dones), .response(resps), .tie(ties));

  // Oscillator bank: each oscillator is a square wave with its own period,
  // derived from one shared tick. Equal periods therefore give identical
  // waveforms.
  initial begin
    ro_out = '0;
    tick_n = 0;
    forever begin
      @(negedge clk);
      tick_n++;
      for (int k = 0; k < 8; k++) ro_out[k] = ((tick_n % per[k]) < (per[k] / 2));
    end
  end

  function automatic logic get_done(input int which);
    return (which == 1) ? done1 : (which == 4) ? done4 : dones;
  endfunction
  function automatic logic get_busy(input int which);
    return (which == 1) ? busy1 : (which == 4) ? busy4 : busys;
  endfunction
  function automatic logic [3:0] get_resp(input int which);
    return (which == 1) ? {3'b0, resp1} : (which == 4) ? resp4 : {3'b0, resps};
  endfunction
  function automatic logic [3:0] get_tie(input int which);
    return (which == 1) ? {3'b0, tie1} : (which == 4) ? tie4 : {3'b0, ties};
  endfunction

  // Reference model: ideal edge count is window/period, clamped to the
  // counter maximum. Done latency is 1 + (S+W+1) per distinct pair + 2 per
  // equal-index pair.
  function automatic exp_t model(input logic [23:0] ch, input int nbits, input int cmax);
    exp_t e;
    int ia, ib, ca, cb;
    e.resp = '0;
    e.tie  = '0;
    e.lat  = 1;
    for (int i = 0; i < nbits; i++) begin
      ia = int'(ch[6*i +: 3]);
      ib = int'(ch[6*i+3 +: 3]);
      if (ia == ib) begin
        e.tie[i] = 1'b1;
        e.lat += 2;
      end else begin
        ca = W / per[ia];
        cb = W / per[ib];
        if (ca > cmax) ca = cmax;
        if (cb > cmax) cb = cmax;
        e.resp[i] = (ca > cb);
        e.tie[i]  = (ca == cb);
        e.lat += S + W + 1;
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("en_pop", (($countones(en1) <= 2) && ($countones(en4) <= 2) &&
                     ($countones(ens) <= 2)), 1);
  endtask

  task automatic pulse_start(input int which, input logic [23:0] ch);
    @(negedge clk);
    case (which)
      1:       begin st1 = 1'b1; ch1 = ch[5:0]; end
      4:       begin st4 = 1'b1; ch4 = ch;      end
      default: begin sts = 1'b1; chs = ch[5:0]; end
    endcase
    @(posedge clk);
    #1;
    t0 = cyc_now;
    st1 = 1'b0; st4 = 1'b0; sts = 1'b0;
    ch1 = ~ch1; ch4 = ~ch4; chs = ~chs;
  endtask

  task automatic start_op(input int which, input logic [23:0] ch);
    sb.push_back(model(ch, (which == 4) ? 4 : 1, (which == 5) ? 15 : 65535));
    pulse_start(which, ch);
  endtask

  task automatic finish_op(input int which);
    exp_t e;
    bit got;
    got = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      tick();
      if (get_done(which) === 1'b1) got = 1'b1;
    end
    e = sb.pop_front();
    check("done_seen", got, 1);
    check("latency", cyc_now - t0, e.lat);
    check("response", get_resp(which), e.resp);
    check("tie", get_tie(which), e.tie);
    check("busy_in_done", get_busy(which), 1);
    tick();
    check("done_one_cycle", get_done(which), 0);
    check("busy_after", get_busy(which), 0);
    check("response_hold", get_resp(which), e.resp);
  endtask

  localparam logic [23:0] MULTI = {3'd2, 3'd4, 3'd6, 3'd7, 3'd3, 3'd3, 3'd1, 3'd0};

  initial begin
    int dc0;
    rst = 1'b1;
    st1 = 1'b0; st4 = 1'b0; sts = 1'b0;
    ch1 = '0; ch4 = '0; chs = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ro_en", en1 | en4 | ens, 0);
    check("rst_busy", {busy1, busy4, busys}, 0);
    check("rst_done", {done1, done4, dones}, 0);
    check("rst_response", {resp1, resp4, resps}, 0);
    check("rst_tie", {tie1, tie4, ties}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick();

    // Basic compare: A=2 (period 6) against B=5 (period 10).
    per[2] = 6; per[5] = 10;
    start_op(1, 24'({3'd5, 3'd2}));
    check("settle_en", en1, 8'b0010_0100);
    check("settle_busy", busy1, 1);
    repeat (30) tick();
    check("measure_en", en1, 8'b0010_0100);
    finish_op(1);

    // Swapped pair.
    start_op(1, 24'({3'd2, 3'd5}));
    finish_op(1);

    // Equal periods give a tie.
    per[2] = 8; per[5] = 8;
    start_op(1, 24'({3'd5, 3'd2}));
    finish_op(1);

    // Multi-bit, including an equal-index pair.
    per[0] = 4; per[1] = 9; per[2] = 12; per[3] = 5;
    per[4] = 3; per[6] = 7; per[7] = 14;
    start_op(4, MULTI);
    check("multi_en_pair0", en4, 8'b0000_0011);
    repeat (69) tick();
    check("multi_en_pair1", en4, 8'b0000_0000);
    check("multi_busy_pair1", busy4, 1);
    repeat (2) tick();
    check("multi_en_pair2", en4, 8'b1100_0000);
    finish_op(4);

    // Start pulsed again mid-measurement with a different challenge.
    per[2] = 6; per[5] = 10;
    dc0 = done1_cnt;
    start_op(1, 24'({3'd5, 3'd2}));
    repeat (30) tick();
    @(negedge clk);
    st1 = 1'b1; ch1 = {3'd2, 3'd5};
    @(posedge clk);
    #1;
    st1 = 1'b0;
    finish_op(1);
    repeat (5) tick();
    check("single_done_pulse", done1_cnt - dc0, 1);

    // Asynchronous reset during bit 2 of the 4-bit instance.
    pulse_start(4, MULTI);
    repeat (100) tick();
    check("pre_rst_tie", tie4, 4'b0010);
    check("pre_rst_en", en4, 8'b1100_0000);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_en", en4, 0);
    check("async_rst_busy", busy4, 0);
    check("async_rst_response", resp4, 0);
    check("async_rst_tie", tie4, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    start_op(4, MULTI);
    finish_op(4);

    // Saturation: 4-bit counters, both channels exceed 15 edges.
    per[0] = 3; per[1] = 4;
    start_op(5, 24'({3'd1, 3'd0}));
    finish_op(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
